// File: rtl/periph_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : periph_bus_arbiter
// Description : Two-master (core LSU, JTAG debug) to one-slave peripheral bus
//               arbiter. Round-robin grants, optional bus lock with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module periph_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    // master 0 (core LSU)
    input  logic              m0_req_i,
    input  logic              m0_lock_i,
    input  logic [3:0]        m0_sel_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic              m0_we_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    // master 1 (JTAG debug module)
    input  logic              m1_req_i,
    input  logic              m1_lock_i,
    input  logic [3:0]        m1_sel_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic              m1_we_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    // slave port
    output logic              s_req_o,
    output logic [3:0]        s_sel_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic              s_we_o,
    output logic [DATA_W-1:0] s_wdata_o,
    input  logic              s_rvalid_i,
    input  logic [DATA_W-1:0] s_rdata_i,
    // status
    output logic              lock_timeout_o,
    output logic [1:0]        owner_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic TIMEOUT_EN = (LOCK_TIMEOUT != 0);

    state_e           state_q, state_d;
    logic             rr_q, rr_d;          // 0: m0 wins a tie, 1: m1 wins
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       armed_q, armed_d;
    logic             timeout_q, timeout_d;

    logic             gnt0, gnt1;          // raw grant decision
    logic             g0, g1;              // grants suppressed while in reset

    // State registers; everything (including an active lock) clears on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            cnt_q     <= '0;
            armed_q   <= 2'b11;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            timeout_q <= timeout_d;
        end
    end

    // Grant decision, lock entry/exit, timeout and re-arming.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_d   = state_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        armed_d   = armed_q;
        timeout_d = 1'b0;

        // A master that drops its lock request may lock again later.
        if (!m0_lock_i) armed_d[0] = 1'b1;
        if (!m1_lock_i) armed_d[1] = 1'b1;

        case (state_q)
            IDLE: begin
                if (m0_req_i && (!m1_req_i || !rr_q)) begin
                    gnt0 = 1'b1;
                end else if (m1_req_i) begin
                    gnt1 = 1'b1;
                end
                if (gnt0) begin
                    rr_d = 1'b1;
                    if (m0_lock_i && armed_q[0]) begin
                        state_d = LOCK0;
                        cnt_d   = '0;
                    end
                end
                if (gnt1) begin
                    rr_d = 1'b0;
                    if (m1_lock_i && armed_q[1]) begin
                        state_d = LOCK1;
                        cnt_d   = '0;
                    end
                end
            end
            LOCK0: begin
                gnt0 = m0_req_i;
                if (TIMEOUT_EN) cnt_d = cnt_q + CNT_W'(1);
                if (!m0_lock_i) begin
                    state_d = IDLE;
                    rr_d    = 1'b1;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    state_d    = IDLE;
                    rr_d       = 1'b1;
                    armed_d[0] = 1'b0;
                    timeout_d  = 1'b1;
                end
            end
            LOCK1: begin
                gnt1 = m1_req_i;
                if (TIMEOUT_EN) cnt_d = cnt_q + CNT_W'(1);
                if (!m1_lock_i) begin
                    state_d = IDLE;
                    rr_d    = 1'b0;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    state_d    = IDLE;
                    rr_d       = 1'b0;
                    armed_d[1] = 1'b0;
                    timeout_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // No access may slip through while reset is held.
    assign g0 = gnt0 & rst_ni;
    assign g1 = gnt1 & rst_ni;

    assign m0_gnt_o = g0;
    assign m1_gnt_o = g1;

    // Request/response steering; ungranted paths are forced to zero.
    always_comb begin
        s_req_o   = g0 | g1;
        s_sel_o   = '0;
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_wdata_o = '0;
        if (g0) begin
            s_sel_o   = m0_sel_i;
            s_addr_o  = m0_addr_i;
            s_we_o    = m0_we_i;
            s_wdata_o = m0_wdata_i;
        end else if (g1) begin
            s_sel_o   = m1_sel_i;
            s_addr_o  = m1_addr_i;
            s_we_o    = m1_we_i;
            s_wdata_o = m1_wdata_i;
        end
    end

    assign m0_rvalid_o = g0 & s_rvalid_i;
    assign m1_rvalid_o = g1 & s_rvalid_i;
    assign m0_rdata_o  = g0 ? s_rdata_i : '0;
    assign m1_rdata_o  = g1 ? s_rdata_i : '0;

    assign lock_timeout_o = timeout_q;
    assign owner_o        = {state_q != IDLE, state_q == LOCK1};

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_periph_bus_arbiter
// Description : Directed, table-driven self-checking bench for the arbiter
//               (instance built with LOCK_TIMEOUT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_periph_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_lock = 0, m0_we = 0;
    logic        m1_req = 0, m1_lock = 0, m1_we = 0;
    logic [3:0]  m0_sel = 0, m1_sel = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
    logic        s_rvalid = 0;
    logic [31:0] s_rdata = 0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_addr, s_wdata;
    logic        lock_to;
    logic [1:0]  owner;

    int total = 0;
    int bad   = 0;

    periph_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_TIMEOUT(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_lock_i(m0_lock), .m0_sel_i(m0_sel),
        .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_lock_i(m1_lock), .m1_sel_i(m1_sel),
        .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .s_req_o(s_req), .s_sel_o(s_sel), .s_addr_o(s_addr), .s_we_o(s_we),
        .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
        .lock_timeout_o(lock_to), .owner_o(owner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        r0, l0, r1, l1, rv;
        logic [31:0] rd;
        logic        g0, g1;
        logic [1:0]  own;
        logic        to;
    } vec_t;

    localparam int NV = 27;
    vec_t vec [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus; addresses/data are tagged so the mux is observable.
    task automatic drive(input logic r0, l0, r1, l1, rv, input logic [31:0] rd, input int tag);
        m0_req = r0;  m0_lock = l0;  m1_req = r1;  m1_lock = l1;
        m0_addr  = 32'h1000_0000 + 32'(tag * 4);
        m1_addr  = 32'h2000_0000 + 32'(tag * 4);
        m0_wdata = 32'hAAAA_0000 + 32'(tag);
        m1_wdata = 32'hBBBB_0000 + 32'(tag);
        m0_sel = 4'h3;  m1_sel = 4'hC;
        m0_we  = 1'b0;  m1_we  = 1'b1;
        s_rvalid = rv;  s_rdata = rd;
    endtask

    // Compare every output against the expected grant/owner/timeout values.
    task automatic expect_out(input string id, input logic g0, g1, input logic [1:0] own,
                              input logic to);
        logic [31:0] ea, ew;
        logic [3:0]  es;
        ea = g0 ? m0_addr  : (g1 ? m1_addr  : 32'h0);
        ew = g0 ? m0_wdata : (g1 ? m1_wdata : 32'h0);
        es = g0 ? 4'h3 : (g1 ? 4'hC : 4'h0);
        chk({id, " m0_gnt"},    64'(m0_gnt),  64'(g0));
        chk({id, " m1_gnt"},    64'(m1_gnt),  64'(g1));
        chk({id, " owner"},     64'(owner),   64'(own));
        chk({id, " lock_to"},   64'(lock_to), 64'(to));
        chk({id, " s_req"},     64'(s_req),   64'(g0 | g1));
        chk({id, " s_addr"},    64'(s_addr),  64'(ea));
        chk({id, " s_wdata"},   64'(s_wdata), 64'(ew));
        chk({id, " s_sel"},     64'(s_sel),   64'(es));
        chk({id, " s_we"},      64'(s_we),    64'(g1));
        chk({id, " m0_rvalid"}, 64'(m0_rvalid), 64'(g0 & s_rvalid));
        chk({id, " m1_rvalid"}, 64'(m1_rvalid), 64'(g1 & s_rvalid));
        chk({id, " m0_rdata"},  64'(m0_rdata),  64'(g0 ? s_rdata : 32'h0));
        chk({id, " m1_rdata"},  64'(m1_rdata),  64'(g1 ? s_rdata : 32'h0));
    endtask

    task automatic step(input logic r0, l0, r1, l1, input int tag,
                        input logic g0, g1, input logic [1:0] own, input logic to);
        @(negedge clk);
        drive(r0, l0, r1, l1, 1'b1, 32'hC0DE_0000 + 32'(tag), tag);
        #1;
        expect_out($sformatf("seq%0d", tag), g0, g1, own, to);
    endtask

    initial begin
        //            r0 l0 r1 l1 rv rdata          g0 g1 own    to
        vec[0]  = '{0, 0, 0, 0, 1, 32'h1111_1111, 0, 0, 2'b00, 0}; // idle
        vec[1]  = '{1, 0, 1, 0, 0, 32'h0,         1, 0, 2'b00, 0}; // tie -> m0
        vec[2]  = '{1, 0, 1, 0, 1, 32'h2222_2222, 0, 1, 2'b00, 0}; // tie -> m1
        vec[3]  = '{1, 0, 1, 0, 1, 32'h3333_3333, 1, 0, 2'b00, 0};
        vec[4]  = '{1, 0, 1, 0, 0, 32'h4444_4444, 0, 1, 2'b00, 0};
        vec[5]  = '{1, 0, 0, 0, 1, 32'hDEAD_BEEF, 1, 0, 2'b00, 0}; // m0 read
        vec[6]  = '{1, 0, 1, 1, 1, 32'h6666_6666, 0, 1, 2'b00, 0}; // m1 locks
        vec[7]  = '{1, 0, 1, 1, 1, 32'h7777_7777, 0, 1, 2'b11, 0};
        vec[8]  = '{1, 0, 1, 1, 0, 32'h8888_8888, 0, 1, 2'b11, 0};
        vec[9]  = '{1, 0, 0, 0, 1, 32'h9999_9999, 0, 0, 2'b11, 0}; // m1 releases
        vec[10] = '{1, 0, 0, 0, 1, 32'hAAAA_AAAA, 1, 0, 2'b00, 0}; // m0 next
        vec[11] = '{0, 0, 1, 0, 1, 32'hBBBB_BBBB, 0, 1, 2'b00, 0};
        vec[12] = '{1, 1, 1, 0, 1, 32'hCCCC_CCCC, 1, 0, 2'b00, 0}; // m0 locks
        vec[13] = '{1, 1, 1, 0, 1, 32'h0000_000D, 1, 0, 2'b10, 0};
        vec[14] = '{1, 1, 1, 0, 1, 32'h0000_000E, 1, 0, 2'b10, 0};
        vec[15] = '{1, 1, 1, 0, 1, 32'h0000_000F, 1, 0, 2'b10, 0};
        vec[16] = '{1, 1, 1, 0, 1, 32'h0000_0010, 1, 0, 2'b10, 0}; // forced release
        vec[17] = '{1, 1, 1, 0, 1, 32'h0000_0011, 0, 1, 2'b00, 1}; // timeout pulse
        vec[18] = '{1, 1, 1, 0, 1, 32'h0000_0012, 1, 0, 2'b00, 0}; // m0 disarmed
        vec[19] = '{1, 1, 1, 0, 1, 32'h0000_0013, 0, 1, 2'b00, 0};
        vec[20] = '{1, 0, 1, 0, 1, 32'h0000_0014, 1, 0, 2'b00, 0}; // m0 rearms
        vec[21] = '{1, 1, 0, 0, 1, 32'h0000_0015, 1, 0, 2'b00, 0}; // m0 relocks
        vec[22] = '{1, 1, 1, 0, 1, 32'h0000_0016, 1, 0, 2'b10, 0};
        vec[23] = '{0, 0, 1, 0, 1, 32'h0000_0017, 0, 0, 2'b10, 0}; // release, m1 held
        vec[24] = '{0, 0, 1, 0, 1, 32'h0000_0018, 0, 1, 2'b00, 0};
        vec[25] = '{0, 1, 0, 0, 1, 32'h0000_0019, 0, 0, 2'b00, 0}; // lock w/o req
        vec[26] = '{0, 0, 1, 0, 1, 32'h0000_001A, 0, 1, 2'b00, 0};

        // Reset state with no requests.
        drive(0, 0, 0, 0, 1'b0, 32'h0, 0);
        repeat (3) @(negedge clk);
        #1;
        expect_out("reset", 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vec[i].r0, vec[i].l0, vec[i].r1, vec[i].l1, vec[i].rv, vec[i].rd, i);
            #1;
            expect_out($sformatf("vec%0d", i), vec[i].g0, vec[i].g1, vec[i].own, vec[i].to);
        end

        // Enter LOCK1, then assert reset asynchronously mid-lock.
        step(0, 0, 1, 1, 100, 0, 1, 2'b00, 0);
        step(0, 0, 1, 1, 101, 0, 1, 2'b11, 0);
        #2;
        m0_req = 1'b1;
        rst_n  = 1'b0;
        #1;
        expect_out("async_rst", 1'b0, 1'b0, 2'b00, 1'b0);

        // Release reset with both masters requesting lock: m0 wins the first tie.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 1, 1, 1'b1, 32'h5A5A_5A5A, 102);
        #1;
        expect_out("post_rst", 1'b1, 1'b0, 2'b00, 1'b0);
        step(1, 1, 1, 1, 103, 1, 0, 2'b10, 0);
        step(1, 0, 1, 1, 104, 1, 0, 2'b10, 0);
        step(1, 0, 1, 1, 105, 0, 1, 2'b00, 0);
        step(1, 0, 1, 0, 106, 0, 1, 2'b11, 0);
        step(0, 0, 0, 0, 107, 0, 0, 2'b00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Two-master to one-slave arbiter for the peripheral bus port (timer, and other req/we/addr/wdata to rvalid/rdata slaves).
- Master 0 is the core LSU; master 1 is the JTAG debug module.
- Grants are round-robin, with an optional lock so one master can own the slave across multi-access sequences (e.g. mtime low then high).
- A lock timeout stops a stuck master from starving the other.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LOCK_TIMEOUT, 16, maximum cycles a master may hold the lock; 0 = no timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mX_req_i  in  1  master X (X=0,1) access request, one access per granted cycle
- mX_lock_i  in  1  master X requests exclusive ownership after its grant
- mX_sel_i  in  4  byte selects
- mX_addr_i  in  ADDR_W  address
- mX_we_i  in  1  write enable
- mX_wdata_i  in  DATA_W  write data
- mX_gnt_o  out  1  access accepted this cycle
- mX_rvalid_o  out  1  slave rvalid routed to granted master
- mX_rdata_o  out  DATA_W  slave rdata routed to granted master
- s_req_o, s_sel_o, s_addr_o, s_we_o, s_wdata_o  out  1/4/ADDR_W/1/DATA_W  to slave
- s_rvalid_i  in  1  slave read valid (combinational, same cycle)
- s_rdata_i  in  DATA_W  slave read data
- lock_timeout_o  out  1  one-cycle pulse after a forced lock release
- owner_o  out  2  {locked, owner_id}, registered

Behaviour:
- Single clock. Reset is asynchronous and active-low (rst_ni); all state is cleared on assertion, including mid-lock.
- Reset state:
  - FSM = IDLE, rr_ptr = 0 (m0 wins the first tie), lock counter = 0, lock_armed[1:0] = 2'b11.
  - lock_timeout_o = 0, owner_o = 0.
  - With no requests, all gnt/rvalid/rdata and all s_* outputs are 0.
- Grant is combinational, zero latency: the access and its response complete in the same cycle as mX_gnt_o.
  - Exactly one of m0_gnt_o/m1_gnt_o is high, or neither; gnt is never high without the matching req.
- Mux:
  - s_* carries the granted master's fields; all s_* are zero when there is no grant.
  - The granted master gets mX_rvalid_o = s_rvalid_i and mX_rdata_o = s_rdata_i.
  - The non-granted master gets rvalid = 0 and rdata = 0.
- FSM states: IDLE, LOCK0, LOCK1.
- IDLE:
  - Only one req: grant it.
  - Both reqs: grant the master selected by rr_ptr.
  - After a grant to X, rr_ptr <= ~X.
  - If the granted master has mX_lock_i = 1 and lock_armed[X] = 1, next state = LOCKX and the counter clears to 0.
- LOCKX:
  - Only master X can be granted, when mX_req_i = 1. The other master's req is held off with gnt = 0; the request must stay asserted and is not queued.
  - The counter increments every LOCKX cycle, whether or not an access happens.
  - Voluntary release: mX_lock_i = 0 in a LOCKX cycle. Any access that cycle is still granted; next state = IDLE; rr_ptr <= ~X.
  - Forced release: LOCK_TIMEOUT != 0 and counter == LOCK_TIMEOUT-1 with lock still high. That cycle is still granted; next state = IDLE; rr_ptr <= ~X; lock_armed[X] <= 0; lock_timeout_o = 1 in the next cycle only.
- lock_armed[X] returns to 1 in the first cycle mX_lock_i is sampled 0. While disarmed, X's grants are ordinary round-robin grants with no lock entry.
- Both masters asserting lock with both requesting in IDLE: only the rr_ptr winner locks.
- owner_o reflects the state register: 2'b10 = LOCK0, 2'b11 = LOCK1, 2'b00 = IDLE.
- Counter width is clog2(LOCK_TIMEOUT+1), minimum 1. It never wraps, because release occurs at LOCK_TIMEOUT-1.
- Lock entry, timeout and arming apply only when a master is actually granted. A master asserting lock without req never locks.

Test Plan:
- Reset then m0_req = m1_req = 1 held for 4 cycles, no lock → grants m0, m1, m0, m1; s_addr follows the granted master's addr each cycle.
- m0 reads addr 0x0 with slave rdata = 0xDEADBEEF, rvalid = 1, while m1 idle → m0_rdata_o = 0xDEADBEEF and m0_rvalid_o = 1 in the same cycle; m1_rdata_o = 0, m1_rvalid_o = 0.
- m1 req+lock writes 0x0 then 0x4 over 3 cycles while m0_req is held high:
  - m1 granted all 3 cycles, m0_gnt = 0, owner_o = 2'b11.
  - After m1 drops lock, m0 is granted the next cycle.
- LOCK_TIMEOUT = 4, m0 holds req+lock indefinitely, m1_req = 1:
  - m0 granted in the entry cycle plus 4 LOCK0 cycles.
  - Next cycle m1 is granted and lock_timeout_o = 1 for exactly 1 cycle.
  - m0 cannot relock until it drops lock for one cycle.
- Assert rst_ni low mid-LOCK1 for 1 cycle → owner_o = 0, all gnt = 0 immediately; after release, m0 wins the first tie.
- Both masters req+lock in IDLE right after reset → m0 granted and locked (owner_o = 2'b10); m1 gnt stays 0 until m0 releases.
